// File: rtl/mod_148_9_dplca_aging_param_if.sv
// Bundles the configuration, TXOP-end event, claim read port and status
// outputs of the DPLCA claim-table aging engine.
//   master : drives aging enable, TXOP-end event (claim/id), aging thresholds, rd_id;
//            observes rd_claim and the status outputs
//   slave  : the aging engine
interface mod_148_9_dplca_aging_param_if #(
    parameter int ID_W  = 8,
    parameter int CNT_W = 16
);
    logic             dplca_aging;
    logic             dplca_txop_end;
    logic [1:0]       dplca_txop_claim;
    logic [ID_W-1:0]  dplca_txop_id;
    logic [CNT_W-1:0] hard_aging_cycles;
    logic [CNT_W-1:0] soft_aging_cycles;
    logic [ID_W-1:0]  rd_id;
    logic [1:0]       rd_claim;
    logic [2:0]       mod_state;
    logic [CNT_W-1:0] long_cnt;
    logic [CNT_W-1:0] short_cnt;
    logic             dplca_new_age;
    logic             dplca_txop_table_upd;

    modport master (
        output dplca_aging, dplca_txop_end, dplca_txop_claim, dplca_txop_id,
               hard_aging_cycles, soft_aging_cycles, rd_id,
        input  rd_claim, mod_state, long_cnt, short_cnt, dplca_new_age,
               dplca_txop_table_upd
    );

    modport slave (
        input  dplca_aging, dplca_txop_end, dplca_txop_claim, dplca_txop_id,
               hard_aging_cycles, soft_aging_cycles, rd_id,
        output rd_claim, mod_state, long_cnt, short_cnt, dplca_new_age,
               dplca_txop_table_upd
    );
endinterface

// File: rtl/mod_148_9_dplca_aging_if.sv
// The DPLCA aging engine bus interface is declared in
// rtl/mod_148_9_dplca_aging_param_if.sv (mod_148_9_dplca_aging_param_if).

// File: rtl/mod_148_9_dplca_aging_param.sv
// DPLCA TXOP claim-table aging engine.
// Keeps the live claim table and a shadow "new" table. Each TXOP end records
// the HARD/SOFT claim of that TXOP id. On id-0 TXOPs (one per PLCA cycle) the
// hard-age counter swaps the shadow table in, and the soft-age counter purges
// SOFT claims from the live table.
// Ports: clk, reset (async, active-high), bus (slave modport: enable, TXOP
// event, thresholds, claim read port, state/counter/event status).
//
// state         | meaning
// DISABLED      | aging off, tables held at NONE
// WAIT_TXOP_END | idle, waiting for a TXOP to end
// TXOP_END      | apply hard/soft aging (id 0 only)
// UPDATE_HARD   | record HARD claim in both tables
// UPDATE_SOFT   | record SOFT claim in both tables unless already HARD
// NOTIFY        | table update flagged; wait for txop_end to drop
module mod_148_9_dplca_aging_param #(
    parameter int N_TXOP = 256,
    parameter int ID_W   = 8,
    parameter int CNT_W  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    mod_148_9_dplca_aging_param_if.slave    bus
);
    localparam logic [1:0] CLAIM_SOFT = 2'b00;
    localparam logic [1:0] CLAIM_HARD = 2'b01;
    localparam logic [1:0] CLAIM_NONE = 2'b10;

    typedef enum logic [2:0] {
        DISABLED      = 3'd0,
        WAIT_TXOP_END = 3'd1,
        TXOP_END      = 3'd2,
        UPDATE_HARD   = 3'd3,
        UPDATE_SOFT   = 3'd4,
        NOTIFY        = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       tbl_q [N_TXOP];
    logic [1:0]       tbl_d [N_TXOP];
    logic [1:0]       new_q [N_TXOP];
    logic [1:0]       new_d [N_TXOP];
    logic [1:0]       claim_q, claim_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [CNT_W-1:0] long_q, long_d;
    logic [CNT_W-1:0] short_q, short_d;
    logic             new_age_q, new_age_d;
    logic             upd_q, upd_d;
    logic             id_ok;

    assign id_ok = int'(id_q) < N_TXOP;

    always_comb begin
        state_d   = state_q;
        tbl_d     = tbl_q;
        new_d     = new_q;
        claim_d   = claim_q;
        id_d      = id_q;
        long_d    = long_q;
        short_d   = short_q;
        new_age_d = new_age_q;
        upd_d     = upd_q;
        if (!bus.dplca_aging) begin
            state_d = DISABLED;
            for (int i = 0; i < N_TXOP; i++) begin
                tbl_d[i] = CLAIM_NONE;
                new_d[i] = CLAIM_NONE;
            end
            long_d    = '0;
            short_d   = '0;
            new_age_d = 1'b0;
            upd_d     = 1'b0;
        end else begin
            case (state_q)
                DISABLED: state_d = WAIT_TXOP_END;
                WAIT_TXOP_END: begin
                    new_age_d = 1'b0;
                    upd_d     = 1'b0;
                    if (bus.dplca_txop_end) begin
                        claim_d = bus.dplca_txop_claim;
                        id_d    = bus.dplca_txop_id;
                        state_d = TXOP_END;
                    end
                end
                TXOP_END: begin
                    if (id_q == '0) begin
                        if (long_q == bus.hard_aging_cycles) begin
                            tbl_d = new_q;
                            for (int i = 0; i < N_TXOP; i++) new_d[i] = CLAIM_NONE;
                            long_d    = '0;
                            new_age_d = 1'b1;
                        end else begin
                            long_d = long_q + CNT_W'(1);
                        end
                        // purge works on the post-swap table so a SOFT entry
                        // promoted from the shadow table is also removed
                        if (short_q == bus.soft_aging_cycles) begin
                            for (int i = 0; i < N_TXOP; i++)
                                if (tbl_d[i] == CLAIM_SOFT) tbl_d[i] = CLAIM_NONE;
                            short_d   = '0;
                            new_age_d = 1'b1;
                        end else begin
                            short_d = short_q + CNT_W'(1);
                        end
                    end
                    if (claim_q == CLAIM_HARD) begin
                        state_d = UPDATE_HARD;
                    end else if (claim_q == CLAIM_SOFT) begin
                        state_d = UPDATE_SOFT;
                    end else begin
                        state_d = NOTIFY;
                        upd_d   = 1'b1;
                    end
                end
                UPDATE_HARD: begin
                    if (id_ok) begin
                        tbl_d[id_q] = CLAIM_HARD;
                        new_d[id_q] = CLAIM_HARD;
                    end
                    state_d = NOTIFY;
                    upd_d   = 1'b1;
                end
                UPDATE_SOFT: begin
                    if (id_ok) begin
                        if (tbl_q[id_q] != CLAIM_HARD) tbl_d[id_q] = CLAIM_SOFT;
                        if (new_q[id_q] != CLAIM_HARD) new_d[id_q] = CLAIM_SOFT;
                    end
                    state_d = NOTIFY;
                    upd_d   = 1'b1;
                end
                NOTIFY: begin
                    if (!bus.dplca_txop_end) begin
                        state_d   = WAIT_TXOP_END;
                        new_age_d = 1'b0;
                        upd_d     = 1'b0;
                    end
                end
                default: state_d = DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= DISABLED;
            for (int i = 0; i < N_TXOP; i++) begin
                tbl_q[i] <= CLAIM_NONE;
                new_q[i] <= CLAIM_NONE;
            end
            claim_q   <= CLAIM_NONE;
            id_q      <= '0;
            long_q    <= '0;
            short_q   <= '0;
            new_age_q <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tbl_q     <= tbl_d;
            new_q     <= new_d;
            claim_q   <= claim_d;
            id_q      <= id_d;
            long_q    <= long_d;
            short_q   <= short_d;
            new_age_q <= new_age_d;
            upd_q     <= upd_d;
        end
    end

    assign bus.rd_claim             = (int'(bus.rd_id) < N_TXOP) ? tbl_q[bus.rd_id] : CLAIM_NONE;
    assign bus.mod_state            = state_q;
    assign bus.long_cnt             = long_q;
    assign bus.short_cnt            = short_q;
    assign bus.dplca_new_age        = new_age_q;
    assign bus.dplca_txop_table_upd = upd_q;
endmodule

// File: tb/tb_mod_148_9_dplca_aging_param.sv
// Bench for the DPLCA claim-table aging engine. Stimulus tasks push the
// expected claim/new_age/update-edge of each TXOP into a queue; a monitor pops
// one entry per rising table-update flag and checks it.
module tb_mod_148_9_dplca_aging_param;
    localparam logic [1:0] SOFT = 2'b00, HARD = 2'b01, NONE = 2'b10, RSVD = 2'b11;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic       mon_sel = 1'b0;
    logic [7:0] mon_rd = '0;
    logic [7:0] stim_rd = '0;

    typedef struct {
        int         probe;
        logic [1:0] claim;
        logic       new_age;
        int         upd_cyc;
        string      name;
    } sb_item_t;
    sb_item_t sb_q[$];

    mod_148_9_dplca_aging_param_if #(.ID_W(8), .CNT_W(16)) bus ();

    mod_148_9_dplca_aging_param #(.N_TXOP(256), .ID_W(8), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.rd_id = mon_sel ? mon_rd : stim_rd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int n = 0;
        while (bus.mod_state !== s && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.mod_state !== s) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: state stuck at %0d expected %0d", name, bus.mod_state, s);
        end
    endtask

    task automatic push(input int probe, input logic [1:0] c, input logic na, input int lat, input string name);
        sb_item_t it;
        it.probe   = probe;
        it.claim   = c;
        it.new_age = na;
        it.upd_cyc = cyc + 1 + lat;
        it.name    = name;
        sb_q.push_back(it);
    endtask

    // one TXOP: txop_end high for 'hold' cycles, then back to idle
    task automatic txop(input logic [1:0] c, input logic [7:0] id, input int probe,
                        input logic [1:0] exp_c, input logic exp_na, input int lat, input string name);
        @(negedge clk);
        bus.dplca_txop_end   = 1'b1;
        bus.dplca_txop_claim = c;
        bus.dplca_txop_id    = id;
        push(probe, exp_c, exp_na, lat, name);
        repeat (2) @(negedge clk);
        bus.dplca_txop_end = 1'b0;
        wait_state(3'd1, {name, "_idle"});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.dplca_txop_end = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_state(3'd1, "reset_exit");
    endtask

    // monitor
    initial begin
        logic     upd_prev;
        sb_item_t it;
        upd_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.dplca_txop_table_upd === 1'b1 && !upd_prev) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_upd: got update at edge %0d expected none", cyc);
                end else begin
                    it = sb_q.pop_front();
                    mon_rd  = 8'(it.probe);
                    mon_sel = 1'b1;
                    #1;
                    check({it.name, "_latency"}, cyc, it.upd_cyc);
                    check({it.name, "_new_age"}, {31'b0, bus.dplca_new_age}, {31'b0, it.new_age});
                    check({it.name, "_claim"}, {30'b0, bus.rd_claim}, {30'b0, it.claim});
                    mon_sel = 1'b0;
                end
            end
            upd_prev = bus.dplca_txop_table_upd;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        reset = 1'b1;
        bus.dplca_aging       = 1'b1;
        bus.dplca_txop_end    = 1'b0;
        bus.dplca_txop_claim  = NONE;
        bus.dplca_txop_id     = '0;
        bus.hard_aging_cycles = 16'hFFFF;
        bus.soft_aging_cycles = 16'hFFFF;
        repeat (3) @(negedge clk);
        check("rst_state", {29'b0, bus.mod_state}, 0);
        check("rst_upd", {31'b0, bus.dplca_txop_table_upd}, 0);
        reset = 1'b0;
        wait_state(3'd1, "first_enable");

        // 1: reset in the middle of NOTIFY
        txop(NONE, 8'd0, 0, NONE, 1'b0, 1, "t1_id0");
        check("t1_long_cnt", {16'b0, bus.long_cnt}, 1);
        @(negedge clk);
        bus.dplca_txop_end = 1'b1; bus.dplca_txop_claim = HARD; bus.dplca_txop_id = 8'd30;
        push(30, HARD, 1'b0, 2, "t1_hard30");
        repeat (4) @(negedge clk);
        check("t1_in_notify", {29'b0, bus.mod_state}, 5);
        #2 reset = 1'b1;
        #1;
        check("t1_rst_state", {29'b0, bus.mod_state}, 0);
        check("t1_rst_upd", {31'b0, bus.dplca_txop_table_upd}, 0);
        check("t1_rst_new_age", {31'b0, bus.dplca_new_age}, 0);
        check("t1_rst_cnts", {bus.long_cnt, bus.short_cnt}, 0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            stim_rd = 8'(i);
            #1;
            if (bus.rd_claim !== NONE) bad++;
        end
        check("t1_rst_table_none", bad, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.dplca_txop_end = 1'b0;
        @(negedge clk);
        check("t1_enable_next", {29'b0, bus.mod_state}, 1);

        // 2: hard aging by swap, threshold 2
        do_reset();
        bus.hard_aging_cycles = 16'd2;
        txop(HARD, 8'd5, 5, HARD, 1'b0, 2, "t2_hard5");
        txop(NONE, 8'd0, 5, HARD, 1'b0, 1, "t2_a1");
        txop(NONE, 8'd0, 5, HARD, 1'b0, 1, "t2_a2");
        txop(NONE, 8'd0, 5, HARD, 1'b1, 1, "t2_a3");
        txop(NONE, 8'd0, 5, HARD, 1'b0, 1, "t2_a4");
        txop(NONE, 8'd0, 5, HARD, 1'b0, 1, "t2_a5");
        txop(NONE, 8'd0, 5, NONE, 1'b1, 1, "t2_a6");

        // 3: soft purge, threshold 1; HARD survives
        do_reset();
        bus.hard_aging_cycles = 16'hFFFF;
        bus.soft_aging_cycles = 16'd1;
        txop(SOFT, 8'd7, 7, SOFT, 1'b0, 2, "t3_soft7");
        txop(HARD, 8'd9, 9, HARD, 1'b0, 2, "t3_hard9");
        txop(NONE, 8'd0, 7, SOFT, 1'b0, 1, "t3_a1");
        txop(NONE, 8'd0, 7, NONE, 1'b1, 1, "t3_a2_purge");
        txop(NONE, 8'd200, 9, HARD, 1'b0, 1, "t3_hard9_kept");

        // 4: both thresholds 0 -> swap then purge on every id-0 TXOP
        do_reset();
        bus.hard_aging_cycles = 16'd0;
        bus.soft_aging_cycles = 16'd0;
        txop(SOFT, 8'd11, 11, SOFT, 1'b0, 2, "t4_soft11");
        txop(NONE, 8'd0, 11, NONE, 1'b1, 1, "t4_swap_purge");
        txop(HARD, 8'd0, 0, HARD, 1'b1, 2, "t4_hard0");

        // 5: HARD wins over SOFT; reserved claim writes nothing
        do_reset();
        bus.hard_aging_cycles = 16'hFFFF;
        bus.soft_aging_cycles = 16'hFFFF;
        txop(HARD, 8'd3, 3, HARD, 1'b0, 2, "t5_hard3");
        txop(SOFT, 8'd3, 3, HARD, 1'b0, 2, "t5_soft3_kept_hard");
        txop(RSVD, 8'd4, 4, NONE, 1'b0, 1, "t5_rsvd4");
        txop(SOFT, 8'd4, 4, SOFT, 1'b0, 2, "t5_soft4");

        // 6: long txop_end, then aging dropped in UPDATE_HARD
        do_reset();
        @(negedge clk);
        bus.dplca_txop_end = 1'b1; bus.dplca_txop_claim = HARD; bus.dplca_txop_id = 8'd20;
        push(20, HARD, 1'b0, 2, "t6_hard20");
        repeat (9) @(negedge clk);
        check("t6_hold_state", {29'b0, bus.mod_state}, 5);
        check("t6_hold_upd", {31'b0, bus.dplca_txop_table_upd}, 1);
        @(negedge clk);
        bus.dplca_txop_end = 1'b0;
        wait_state(3'd1, "t6_idle");
        check("t6_upd_cleared", {31'b0, bus.dplca_txop_table_upd}, 0);
        @(negedge clk);
        bus.dplca_txop_end = 1'b1; bus.dplca_txop_claim = HARD; bus.dplca_txop_id = 8'd21;
        repeat (2) @(negedge clk);
        check("t6_in_update_hard", {29'b0, bus.mod_state}, 3);
        bus.dplca_aging = 1'b0;
        bus.dplca_txop_end = 1'b0;
        @(negedge clk);
        check("t6_dis_state", {29'b0, bus.mod_state}, 0);
        check("t6_dis_upd", {31'b0, bus.dplca_txop_table_upd}, 0);
        stim_rd = 8'd21;
        #1 check("t6_no_write21", {30'b0, bus.rd_claim}, {30'b0, NONE});
        stim_rd = 8'd20;
        #1 check("t6_cleared20", {30'b0, bus.rd_claim}, {30'b0, NONE});
        @(negedge clk);
        bus.dplca_aging = 1'b1;
        @(negedge clk);
        check("t6_reenable", {29'b0, bus.mod_state}, 1);

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
